// File: rtl/imem_boot_ctrl_pkg.sv
// Shared definitions for the instruction-memory boot controller:
// the controller state encoding and the default parameter values.
package imem_boot_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   localparam int          DATA_WIDTH_DEF = 32;
   localparam int          DEPTH_DEF      = 100;
   localparam logic [31:0] NOP_WORD_DEF   = 32'h0000_0000;

endpackage

// File: rtl/imem_boot_ctrl.sv
// Shares the single instruction-memory port between the boot loader and the
// fetch stage: IDLE -> LOAD (stream words in) -> RUN (serve fetches).
module imem_boot_ctrl
   import imem_boot_ctrl_pkg::*;
#(
   parameter int                   DataWidth = DATA_WIDTH_DEF,
   parameter int                   Depth     = DEPTH_DEF,
   parameter logic [DataWidth-1:0] NOP_WORD  = DataWidth'(NOP_WORD_DEF)
) (
   input  logic                 clk,
   input  logic                 RST,
   input  logic                 load_start,
   input  logic                 ld_valid,
   input  logic [DataWidth-1:0] ld_data,
   input  logic                 ld_last,
   output logic                 ld_ready,
   input  logic                 fetch_req,
   input  logic [DataWidth-1:0] fetch_addr,
   output logic                 fetch_valid,
   output logic [DataWidth-1:0] fetch_instr,
   output logic                 fetch_fault,
   output logic                 cpu_stall,
   output logic                 load_ovf,
   output logic [DataWidth-1:0] mem_wr_data,
   output logic [DataWidth-1:0] mem_addr,
   output logic                 mem_wr_en,
   input  logic [DataWidth-1:0] mem_rd_data
);

   localparam int CntWidth = (Depth > 1) ? $clog2(Depth) : 1;

   state_t                state_reg, state_next;
   logic [CntWidth-1:0]   count_reg, count_next;
   logic                  load_ovf_reg, load_ovf_next;
   logic                  fetch_valid_reg, fetch_valid_next;
   logic [DataWidth-1:0]  fetch_instr_reg, fetch_instr_next;
   logic                  fetch_fault_reg, fetch_fault_next;

   logic [DataWidth-1:0]  word_idx;
   logic                  in_range;
   logic                  transfer;
   logic                  at_last_slot;

   assign word_idx     = fetch_addr >> 2;
   assign in_range     = (word_idx < DataWidth'(Depth));
   assign transfer     = (state_reg == ST_LOAD) && ld_valid;
   assign at_last_slot = (count_reg == CntWidth'(Depth - 1));

   always_ff @(posedge clk) begin
      if (RST) begin
         state_reg       <= ST_IDLE;
         count_reg       <= '0;
         load_ovf_reg    <= 1'b0;
         fetch_valid_reg <= 1'b0;
         fetch_instr_reg <= '0;
         fetch_fault_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         count_reg       <= count_next;
         load_ovf_reg    <= load_ovf_next;
         fetch_valid_reg <= fetch_valid_next;
         fetch_instr_reg <= fetch_instr_next;
         fetch_fault_reg <= fetch_fault_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      count_next       = count_reg;
      load_ovf_next    = load_ovf_reg;
      fetch_valid_next = 1'b0;
      fetch_instr_next = fetch_instr_reg;
      fetch_fault_next = fetch_fault_reg;
      ld_ready         = 1'b0;
      mem_wr_en        = 1'b0;
      mem_wr_data      = ld_data;
      mem_addr         = DataWidth'(count_reg);

      unique case (state_reg)
         ST_IDLE: begin
            if (load_start) begin
               state_next    = ST_LOAD;
               count_next    = '0;
               load_ovf_next = 1'b0;
            end
         end

         ST_LOAD: begin
            ld_ready  = 1'b1;
            mem_wr_en = transfer;
            if (transfer) begin
               // The counter saturates at the last slot so it never leaves the memory.
               if (!at_last_slot)
                  count_next = count_reg + 1'b1;
               if (ld_last) begin
                  state_next = ST_RUN;
               end else if (at_last_slot) begin
                  state_next    = ST_RUN;
                  load_ovf_next = 1'b1;
               end
            end
         end

         ST_RUN: begin
            mem_addr = in_range ? word_idx : '0;
            if (load_start) begin
               // Re-boot takes priority; any fetch requested this cycle is dropped.
               state_next    = ST_LOAD;
               count_next    = '0;
               load_ovf_next = 1'b0;
            end else if (fetch_req) begin
               fetch_valid_next = 1'b1;
               fetch_instr_next = in_range ? mem_rd_data : NOP_WORD;
               fetch_fault_next = !in_range;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign cpu_stall   = (state_reg != ST_RUN);
   assign load_ovf    = load_ovf_reg;
   assign fetch_valid = fetch_valid_reg;
   assign fetch_instr = fetch_instr_reg;
   assign fetch_fault = fetch_fault_reg;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Scoreboard bench for imem_boot_ctrl: a behavioural memory sits beside the DUT,
// expected writes and fetch results are queued by stimulus and popped by monitors.
module tb_imem_boot_ctrl;

   localparam int          DW    = 32;
   localparam int          DEPTH = 100;
   localparam logic [31:0] NOP   = 32'h0000_0000;

   logic          clk;
   logic          RST;
   logic          load_start;
   logic          ld_valid;
   logic [DW-1:0] ld_data;
   logic          ld_last;
   logic          ld_ready;
   logic          fetch_req;
   logic [DW-1:0] fetch_addr;
   logic          fetch_valid;
   logic [DW-1:0] fetch_instr;
   logic          fetch_fault;
   logic          cpu_stall;
   logic          load_ovf;
   logic [DW-1:0] mem_wr_data;
   logic [DW-1:0] mem_addr;
   logic          mem_wr_en;
   logic [DW-1:0] mem_rd_data;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;
   int wr_idx = 0;

   logic [31:0] bmem    [0:DEPTH-1];
   logic [31:0] ref_mem [0:DEPTH-1];

   logic [31:0] exp_instr_q [$];
   logic        exp_fault_q [$];
   logic [31:0] exp_waddr_q [$];
   logic [31:0] exp_wdata_q [$];

   imem_boot_ctrl #(.DataWidth(DW), .Depth(DEPTH), .NOP_WORD(NOP)) dut (
      .clk         (clk),
      .RST         (RST),
      .load_start  (load_start),
      .ld_valid    (ld_valid),
      .ld_data     (ld_data),
      .ld_last     (ld_last),
      .ld_ready    (ld_ready),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_valid (fetch_valid),
      .fetch_instr (fetch_instr),
      .fetch_fault (fetch_fault),
      .cpu_stall   (cpu_stall),
      .load_ovf    (load_ovf),
      .mem_wr_data (mem_wr_data),
      .mem_addr    (mem_addr),
      .mem_wr_en   (mem_wr_en),
      .mem_rd_data (mem_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory with a combinational read port.
   logic [6:0] rd_idx;
   assign rd_idx      = mem_addr[6:0];
   assign mem_rd_data = (mem_addr < DEPTH) ? bmem[rd_idx] : 32'hDEAD_BEEF;

   always @(posedge clk) begin
      if (mem_wr_en === 1'b1 && mem_addr < DEPTH)
         bmem[rd_idx] <= mem_wr_data;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitors: every write strobe and every fetch result must match the head of its queue.
   always @(negedge clk) begin
      if (mon_en) begin
         if (mem_wr_en === 1'b1) begin
            if (exp_waddr_q.size() == 0) begin
               chk("unexpected_write", {31'd0, mem_wr_en}, 32'd0);
            end else begin
               chk("write_addr", mem_addr, exp_waddr_q.pop_front());
               chk("write_data", mem_wr_data, exp_wdata_q.pop_front());
            end
         end
         if (fetch_valid !== 1'b0) begin
            if (exp_instr_q.size() == 0) begin
               chk("unexpected_fetch_valid", {31'd0, fetch_valid}, 32'd0);
            end else begin
               chk("fetch_instr", fetch_instr, exp_instr_q.pop_front());
               chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, exp_fault_q.pop_front()});
            end
         end
      end
   end

   task automatic start_load(input bit with_fetch);
      load_start = 1'b1;
      fetch_req  = with_fetch;
      fetch_addr = 32'h4;
      step();
      load_start = 1'b0;
      fetch_req  = 1'b0;
      wr_idx     = 0;
   endtask

   // One loader word, preceded by a few idle cycles carrying noise the controller must ignore.
   task automatic load_word(input logic [31:0] d, input bit last);
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
         ld_valid   = 1'b0;
         ld_last    = 1'($urandom_range(0, 1));
         fetch_req  = 1'($urandom_range(0, 1));
         fetch_addr = $urandom_range(0, 4 * DEPTH);
         load_start = 1'($urandom_range(0, 1));
         step();
      end
      fetch_req  = 1'b0;
      load_start = 1'b0;
      ld_valid   = 1'b1;
      ld_data    = d;
      ld_last    = last;
      exp_waddr_q.push_back(wr_idx);
      exp_wdata_q.push_back(d);
      ref_mem[wr_idx] = d;
      wr_idx++;
      step();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   task automatic load_program(input int n);
      for (int i = 0; i < n; i++)
         load_word($urandom, (i == n - 1));
   endtask

   task automatic do_fetch(input logic [31:0] a);
      logic [31:0] idx;
      idx = a >> 2;
      fetch_req  = 1'b1;
      fetch_addr = a;
      if (idx < DEPTH) begin
         exp_instr_q.push_back(ref_mem[idx]);
         exp_fault_q.push_back(1'b0);
      end else begin
         exp_instr_q.push_back(NOP);
         exp_fault_q.push_back(1'b1);
      end
      step();
      fetch_req = 1'b0;
   endtask

   task automatic random_fetches(input int n);
      for (int i = 0; i < n; i++) begin
         case ($urandom_range(0, 3))
            0: do_fetch($urandom);
            1: do_fetch(4 * $urandom_range(DEPTH, DEPTH + 50) + $urandom_range(0, 3));
            default: do_fetch(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(0, 3));
         endcase
         if ($urandom_range(0, 2) == 0)
            step();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         bmem[i]    = 32'd0;
         ref_mem[i] = 32'd0;
      end
      RST = 1'b1; load_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
      ld_last = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
      repeat (2) step();

      chk("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
      chk("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
      chk("rst_fetch_instr", fetch_instr, 32'd0);
      chk("rst_fetch_fault", {31'd0, fetch_fault}, 32'd0);
      chk("rst_load_ovf", {31'd0, load_ovf}, 32'd0);
      chk("rst_cpu_stall", {31'd0, cpu_stall}, 32'd1);
      chk("rst_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
      RST    = 1'b0;
      mon_en = 1'b1;

      // Fetch while idle is ignored.
      fetch_req = 1'b1;
      step();
      fetch_req = 1'b0;
      chk("idle_fetch_ignored", {31'd0, fetch_valid}, 32'd0);
      chk("idle_stall", {31'd0, cpu_stall}, 32'd1);

      // Three-word boot.
      start_load(1'b0);
      chk("load_ld_ready", {31'd0, ld_ready}, 32'd1);
      chk("load_stall", {31'd0, cpu_stall}, 32'd1);
      load_word(32'h11, 1'b0);
      load_word(32'h22, 1'b0);
      load_word(32'h33, 1'b1);
      chk("boot3_stall", {31'd0, cpu_stall}, 32'd0);
      chk("boot3_ovf", {31'd0, load_ovf}, 32'd0);
      chk("boot3_ld_ready", {31'd0, ld_ready}, 32'd0);

      // Back-to-back fetches then an out-of-range fetch.
      do_fetch(32'h4);
      chk("b2b_valid_1", {31'd0, fetch_valid}, 32'd1);
      do_fetch(32'h8);
      chk("b2b_valid_2", {31'd0, fetch_valid}, 32'd1);
      step();
      chk("idle_valid_low", {31'd0, fetch_valid}, 32'd0);
      chk("instr_hold", fetch_instr, 32'h33);
      do_fetch(4 * DEPTH);
      chk("oor_valid", {31'd0, fetch_valid}, 32'd1);
      step();
      chk("fault_hold", {31'd0, fetch_fault}, 32'd1);

      // Overflow: Depth words with no ld_last.
      start_load(1'b0);
      for (int i = 0; i < DEPTH; i++)
         load_word($urandom, 1'b0);
      chk("ovf_flag", {31'd0, load_ovf}, 32'd1);
      chk("ovf_stall", {31'd0, cpu_stall}, 32'd0);
      chk("ovf_ld_ready", {31'd0, ld_ready}, 32'd0);
      ld_valid = 1'b1;
      step();
      ld_valid = 1'b0;
      do_fetch(4 * (DEPTH - 1));
      do_fetch(32'h0);

      // Reset in the middle of a five-word load, then a fresh load from address 0.
      start_load(1'b0);
      chk("reload_ovf_cleared", {31'd0, load_ovf}, 32'd0);
      load_word($urandom, 1'b0);
      load_word($urandom, 1'b0);
      RST = 1'b1;
      step();
      RST = 1'b0;
      chk("midrst_stall", {31'd0, cpu_stall}, 32'd1);
      chk("midrst_ld_ready", {31'd0, ld_ready}, 32'd0);
      chk("midrst_ovf", {31'd0, load_ovf}, 32'd0);
      start_load(1'b0);
      load_program(5);
      for (int i = 0; i < 5; i++)
         do_fetch(4 * i);

      // Re-boot request colliding with a fetch: load_start wins.
      start_load(1'b1);
      chk("reboot_valid_low", {31'd0, fetch_valid}, 32'd0);
      chk("reboot_stall", {31'd0, cpu_stall}, 32'd1);
      chk("reboot_ld_ready", {31'd0, ld_ready}, 32'd1);
      load_program(4);

      // Randomized boot/fetch rounds.
      for (int r = 0; r < 6; r++) begin
         random_fetches(20);
         start_load(1'($urandom_range(0, 1)));
         load_program($urandom_range(1, 12));
         chk("rand_ovf", {31'd0, load_ovf}, 32'd0);
         chk("rand_stall", {31'd0, cpu_stall}, 32'd0);
      end
      random_fetches(20);

      repeat (3) step();
      chk("fetch_queue_drained", exp_instr_q.size(), 32'd0);
      chk("write_queue_drained", exp_waddr_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
